// File: rtl/read_pkg.sv
// Shared types and helpers for the DDR5 PHY read manager.
package read_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PRE = 3'd1,
    ST_DATA     = 3'd2,
    ST_CRC      = 3'd3,
    ST_POST     = 3'd4
  } rd_state_e;

  localparam logic [1:0] BL_16 = 2'b00;
  localparam logic [1:0] BC_8  = 2'b01;
  localparam logic [1:0] BL_32 = 2'b10;

  // Per-burst configuration, captured with the read command.
  typedef struct packed {
    logic [1:0] bl;
    logic       crc;
    logic [2:0] pre;
    logic [1:0] post;
  } rd_cfg_t;

  // Burst length in clock cycles (two beats per cycle); code 11 behaves as BL16.
  function automatic logic [4:0] burst_cycles(input logic [1:0] bl);
    case (bl)
      BC_8:    return 5'd4;
      BL_32:   return 5'd16;
      default: return 5'd8;
    endcase
  endfunction

  // Out-of-range preamble lengths fall back to the longest legal one.
  function automatic logic [2:0] clamp_pre(input logic [2:0] p);
    return (p == 3'd0 || p > 3'd4) ? 3'd4 : p;
  endfunction

endpackage

// File: rtl/read_manager_if.sv
// Controller/PHY-side signal bundle of the read manager.
interface read_manager_if #(parameter int N = 4);
  logic           i_enable;
  logic           i_rd_en;
  logic           i_crc_en;
  logic [1:0]     i_burstlength;
  logic [2:0]     i_precycle;
  logic [1:0]     i_postcycle;
  logic [7:0]     i_pre_pattern;
  logic [2*N-1:0] i_DQ;
  logic [1:0]     i_DQS;
  logic [2*N-1:0] i_crc_code;
  logic [2*N-1:0] o_rd_data;
  logic           o_rd_data_valid;
  logic [2*N-1:0] o_crc_data;
  logic           o_crc_enable;
  logic           o_crc_error;
  logic           o_preamble_error;
  logic           o_cmd_overflow;
  logic           o_busy;
  logic [2:0]     o_fsm_state;

  modport master (
    output i_enable, i_rd_en, i_crc_en, i_burstlength, i_precycle, i_postcycle,
           i_pre_pattern, i_DQ, i_DQS, i_crc_code,
    input  o_rd_data, o_rd_data_valid, o_crc_data, o_crc_enable, o_crc_error,
           o_preamble_error, o_cmd_overflow, o_busy, o_fsm_state
  );

  modport slave (
    input  i_enable, i_rd_en, i_crc_en, i_burstlength, i_precycle, i_postcycle,
           i_pre_pattern, i_DQ, i_DQS, i_crc_code,
    output o_rd_data, o_rd_data_valid, o_crc_data, o_crc_enable, o_crc_error,
           o_preamble_error, o_cmd_overflow, o_busy, o_fsm_state
  );
endinterface

// File: rtl/read_preamble_detect.sv
// DQS preamble search: history shift register, masked pattern compare, timeout counter.
module read_preamble_detect #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active_i,
  input  logic [1:0] dqs_i,
  input  logic [7:0] pattern_i,
  input  logic [2:0] prec_i,
  output logic       detect_o,
  output logic       timeout_o
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [7:0]    hist_q, hist_d;
  logic [TW-1:0] tmo_q;
  logic [7:0]    mask;

  // Compare includes the pair arriving this cycle so data can follow the preamble directly.
  always_comb begin
    hist_d = {hist_q[5:0], dqs_i};
    case (prec_i)
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0F;
      3'd3:    mask = 8'h3F;
      default: mask = 8'hFF;
    endcase
    detect_o  = active_i && (((hist_d ^ pattern_i) & mask) == 8'h00);
    timeout_o = active_i && !detect_o && (tmo_q == TW'(TIMEOUT - 1));
  end

  // History and timeout restart from zero on every entry to the search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      tmo_q  <= '0;
    end else if (!active_i) begin
      hist_q <= '0;
      tmo_q  <= '0;
    end else begin
      hist_q <= hist_d;
      tmo_q  <= tmo_q + TW'(1);
    end
  end
endmodule

// File: rtl/read_manager.sv
// DDR5 PHY read manager: preamble search, burst capture, optional CRC check, postamble.
module read_manager
  import read_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  read_manager_if.slave bus
);
  rd_state_e      state_q, state_d;
  rd_cfg_t        cfg_q, cfg_d, pcfg_q, pcfg_d, new_cfg;
  logic           pend_q, pend_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           detect, timeout, rd_acc, consume, ovf;
  logic           last_beat, post_last, en;
  logic [2*N-1:0] rd_data_q, crc_data_q;
  logic           valid_q, crc_en_q, crc_err_q, pre_err_q, ovf_q;

  assign en        = bus.i_enable;
  assign rd_acc    = bus.i_rd_en && en;
  assign new_cfg   = '{bl: bus.i_burstlength, crc: bus.i_crc_en,
                       pre: clamp_pre(bus.i_precycle), post: bus.i_postcycle};
  assign last_beat = (cnt_q == burst_cycles(cfg_q.bl) - 5'd1);
  assign post_last = (cfg_q.post <= 2'd1) || (cnt_q != 5'd0);

  read_preamble_detect #(.TIMEOUT(TIMEOUT)) u_pre (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .active_i  (state_q == ST_WAIT_PRE && en),
    .dqs_i     (bus.i_DQS),
    .pattern_i (bus.i_pre_pattern),
    .prec_i    (cfg_q.pre),
    .detect_o  (detect),
    .timeout_o (timeout)
  );

  // Next state, shadow config and pending-command bookkeeping.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    pcfg_d  = pcfg_q;
    pend_d  = pend_q;
    consume = 1'b0;
    ovf     = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (pend_q) begin
            state_d = ST_WAIT_PRE; cfg_d = pcfg_q; consume = 1'b1;
          end else if (rd_acc) begin
            state_d = ST_WAIT_PRE; cfg_d = new_cfg;
          end
        ST_WAIT_PRE:
          if (detect)       state_d = ST_DATA;
          else if (timeout) state_d = ST_IDLE;
        ST_DATA:
          if (last_beat) begin
            if (cfg_q.crc) state_d = ST_CRC;
            else if (pend_q) begin
              state_d = ST_WAIT_PRE; cfg_d = pcfg_q; consume = 1'b1;
            end else state_d = ST_POST;
          end
        ST_CRC:
          if (pend_q) begin
            state_d = ST_WAIT_PRE; cfg_d = pcfg_q; consume = 1'b1;
          end else state_d = ST_POST;
        ST_POST:
          if (post_last) begin
            if (pend_q) begin
              state_d = ST_WAIT_PRE; cfg_d = pcfg_q; consume = 1'b1;
            end else state_d = ST_IDLE;
          end
        default: state_d = ST_IDLE;
      endcase
      if (consume) pend_d = 1'b0;
      // A command that cannot start now is parked; a second one is dropped.
      if (rd_acc && (state_q != ST_IDLE || pend_q)) begin
        if (pend_q && !consume) ovf = 1'b1;
        else begin
          pend_d = 1'b1;
          pcfg_d = new_cfg;
        end
      end
    end
    // Shared beat/postamble counter restarts on every state change.
    if (state_d != state_q || !(state_q == ST_DATA || state_q == ST_POST)) cnt_d = 5'd0;
    else cnt_d = cnt_q + 5'd1;
  end

  // State, configuration and counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      pcfg_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pcfg_q  <= pcfg_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered read data, CRC stream and error pulses (one cycle behind the input).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_data_q  <= '0;
      valid_q    <= 1'b0;
      crc_data_q <= '0;
      crc_en_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      pre_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q    <= (state_q == ST_DATA) && en;
      rd_data_q  <= ((state_q == ST_DATA) && en) ? bus.i_DQ : '0;
      crc_en_q   <= (state_q == ST_DATA) && en && cfg_q.crc;
      crc_data_q <= ((state_q == ST_DATA) && en && cfg_q.crc) ? bus.i_DQ : '0;
      crc_err_q  <= (state_q == ST_CRC) && en && (bus.i_DQ != bus.i_crc_code);
      pre_err_q  <= timeout && en;
      ovf_q      <= ovf;
    end
  end

  // Qualifiers drop combinationally when the block is disabled.
  assign bus.o_rd_data        = rd_data_q;
  assign bus.o_rd_data_valid  = valid_q && en;
  assign bus.o_crc_data       = crc_data_q;
  assign bus.o_crc_enable     = crc_en_q && en;
  assign bus.o_crc_error      = crc_err_q;
  assign bus.o_preamble_error = pre_err_q;
  assign bus.o_cmd_overflow   = ovf_q;
  assign bus.o_busy           = (state_q != ST_IDLE);
  assign bus.o_fsm_state      = state_q;
endmodule

// File: tb/tb_read_manager.sv
// Directed self-checking bench for read_manager (N=4, TIMEOUT=16).
module tb_read_manager;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_manager_if #(.N(4)) bus();

  read_manager #(.N(4), .TIMEOUT(16)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] bl, input logic crc, input logic [2:0] pre, input logic [1:0] post);
    bus.i_burstlength = bl;
    bus.i_crc_en      = crc;
    bus.i_precycle    = pre;
    bus.i_postcycle   = post;
  endtask

  task automatic cmd();
    bus.i_rd_en = 1'b1;
    tick();
    bus.i_rd_en = 1'b0;
  endtask

  // Preamble for pattern 8'h0C with two cycles: pair 11 then pair 00.
  task automatic pre2();
    bus.i_DQS = 2'b11;
    tick();
    bus.i_DQS = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.o_busy, bus.o_fsm_state} !== 4'h0)
      $display("FAIL reset_state got %b%03b exp 0000", bus.o_busy, bus.o_fsm_state);
    checks++;
    if ({bus.o_rd_data_valid, bus.o_rd_data, bus.o_crc_enable, bus.o_crc_data} !== 18'h0)
      $display("FAIL reset_data got %b %h %b %h exp zeros", bus.o_rd_data_valid, bus.o_rd_data,
               bus.o_crc_enable, bus.o_crc_data);
    checks++;
    if ({bus.o_crc_error, bus.o_preamble_error, bus.o_cmd_overflow} !== 3'b000)
      $display("FAIL reset_pulses got %b%b%b exp 000", bus.o_crc_error, bus.o_preamble_error,
               bus.o_cmd_overflow);
    if (bus.o_busy !== 1'b0 || bus.o_fsm_state !== 3'd0 || bus.o_rd_data_valid !== 1'b0 ||
        bus.o_rd_data !== 8'h0 || bus.o_crc_enable !== 1'b0 || bus.o_crc_data !== 8'h0 ||
        bus.o_crc_error !== 1'b0 || bus.o_preamble_error !== 1'b0 || bus.o_cmd_overflow !== 1'b0)
      errors++;
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bl16();
    cfg(2'b00, 1'b0, 3'd2, 2'd2);
    bus.i_pre_pattern = 8'h0C;
    cmd();
    checks++;
    if (bus.o_fsm_state !== 3'd1) begin
      errors++; $display("FAIL bl16_wait_pre state %0d exp 1", bus.o_fsm_state);
    end
    pre2();
    checks++;
    if (bus.o_fsm_state !== 3'd2) begin
      errors++; $display("FAIL bl16_detect state %0d exp 2", bus.o_fsm_state);
    end
    for (int i = 0; i < 8; i++) begin
      bus.i_DQ = 8'(i + 1);
      tick();
      checks++;
      if ({bus.o_rd_data_valid, bus.o_rd_data} !== {1'b1, 8'(i + 1)}) begin
        errors++; $display("FAIL bl16_beat%0d got v=%b d=%h exp v=1 d=%h", i, bus.o_rd_data_valid,
                           bus.o_rd_data, 8'(i + 1));
      end
      checks++;
      if ({bus.o_crc_enable, bus.o_crc_error, bus.o_preamble_error, bus.o_cmd_overflow} !== 4'h0) begin
        errors++; $display("FAIL bl16_flags%0d got %b%b%b%b exp 0000", i, bus.o_crc_enable,
                           bus.o_crc_error, bus.o_preamble_error, bus.o_cmd_overflow);
      end
    end
    bus.i_DQ = 8'h00;
    checks++;
    if ({bus.o_busy, bus.o_fsm_state} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL bl16_post state %0d busy %b exp 4/1", bus.o_fsm_state, bus.o_busy);
    end
    tick();
    checks++;
    if ({bus.o_rd_data_valid, bus.o_fsm_state} !== {1'b0, 3'd4}) begin
      errors++; $display("FAIL bl16_post2 v=%b state %0d exp 0/4", bus.o_rd_data_valid, bus.o_fsm_state);
    end
    tick();
    checks++;
    if ({bus.o_busy, bus.o_fsm_state} !== 4'h0) begin
      errors++; $display("FAIL bl16_idle state %0d busy %b exp 0/0", bus.o_fsm_state, bus.o_busy);
    end
  endtask

  task automatic test_crc(input logic bad);
    cfg(2'b01, 1'b1, 3'd2, 2'd0);
    bus.i_pre_pattern = 8'h0C;
    bus.i_crc_code    = 8'h5A;
    cmd();
    pre2();
    for (int i = 0; i < 4; i++) begin
      bus.i_DQ = 8'hA0 + 8'(i);
      tick();
      checks++;
      if ({bus.o_crc_enable, bus.o_crc_data, bus.o_rd_data_valid, bus.o_rd_data} !==
          {1'b1, 8'hA0 + 8'(i), 1'b1, 8'hA0 + 8'(i)}) begin
        errors++; $display("FAIL crc_beat%0d got ce=%b cd=%h v=%b d=%h exp %h", i, bus.o_crc_enable,
                           bus.o_crc_data, bus.o_rd_data_valid, bus.o_rd_data, 8'hA0 + 8'(i));
      end
    end
    checks++;
    if (bus.o_fsm_state !== 3'd3) begin
      errors++; $display("FAIL crc_state got %0d exp 3", bus.o_fsm_state);
    end
    bus.i_DQ = bad ? 8'h5B : 8'h5A;
    tick();
    checks++;
    if ({bus.o_crc_error, bus.o_crc_enable, bus.o_rd_data_valid, bus.o_fsm_state} !== {bad, 2'b00, 3'd4}) begin
      errors++; $display("FAIL crc_check bad=%b got err=%b ce=%b v=%b st=%0d exp err=%b ce=0 v=0 st=4", bad,
                         bus.o_crc_error, bus.o_crc_enable, bus.o_rd_data_valid, bus.o_fsm_state, bad);
    end
    bus.i_DQ = 8'h00;
    tick();
    checks++;
    if ({bus.o_crc_error, bus.o_fsm_state} !== 4'h0) begin
      errors++; $display("FAIL crc_end got err=%b st=%0d exp 0/0", bus.o_crc_error, bus.o_fsm_state);
    end
  endtask

  task automatic test_timeout();
    cfg(2'b00, 1'b0, 3'd2, 2'd0);
    bus.i_pre_pattern = 8'h0C;
    bus.i_DQS = 2'b00;
    cmd();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        checks++;
        if ({bus.o_preamble_error, bus.o_fsm_state} !== {1'b0, 3'd1}) begin
          errors++; $display("FAIL tmo_early got err=%b st=%0d exp 0/1", bus.o_preamble_error, bus.o_fsm_state);
        end
      end
    end
    checks++;
    if ({bus.o_preamble_error, bus.o_fsm_state} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL tmo_pulse got err=%b st=%0d exp 1/0", bus.o_preamble_error, bus.o_fsm_state);
    end
    tick();
    checks++;
    if (bus.o_preamble_error !== 1'b0) begin
      errors++; $display("FAIL tmo_single got %b exp 0", bus.o_preamble_error);
    end
  endtask

  task automatic test_back_to_back();
    cfg(2'b01, 1'b0, 3'd2, 2'd2);
    bus.i_pre_pattern = 8'h0C;
    cmd();
    pre2();
    bus.i_DQ = 8'hC0; bus.i_rd_en = 1'b1;
    tick();
    checks++;
    if ({bus.o_cmd_overflow, bus.o_rd_data} !== {1'b0, 8'hC0}) begin
      errors++; $display("FAIL b2b_pend got ovf=%b d=%h exp 0/c0", bus.o_cmd_overflow, bus.o_rd_data);
    end
    bus.i_DQ = 8'hC1;
    tick();
    bus.i_rd_en = 1'b0;
    checks++;
    if (bus.o_cmd_overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_ovf got %b exp 1", bus.o_cmd_overflow);
    end
    bus.i_DQ = 8'hC2;
    tick();
    checks++;
    if (bus.o_cmd_overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_ovf_single got %b exp 0", bus.o_cmd_overflow);
    end
    bus.i_DQ = 8'hC3;
    tick();
    checks++;
    if ({bus.o_fsm_state, bus.o_rd_data_valid, bus.o_rd_data} !== {3'd1, 1'b1, 8'hC3}) begin
      errors++; $display("FAIL b2b_interamble got st=%0d v=%b d=%h exp 1/1/c3", bus.o_fsm_state,
                         bus.o_rd_data_valid, bus.o_rd_data);
    end
    pre2();
    checks++;
    if (bus.o_fsm_state !== 3'd2) begin
      errors++; $display("FAIL b2b_detect2 got %0d exp 2", bus.o_fsm_state);
    end
    for (int i = 0; i < 4; i++) begin
      bus.i_DQ = 8'hD0 + 8'(i);
      tick();
      checks++;
      if ({bus.o_rd_data_valid, bus.o_rd_data} !== {1'b1, 8'hD0 + 8'(i)}) begin
        errors++; $display("FAIL b2b_beat%0d got v=%b d=%h exp 1/%h", i, bus.o_rd_data_valid,
                           bus.o_rd_data, 8'hD0 + 8'(i));
      end
    end
    checks++;
    if (bus.o_fsm_state !== 3'd4) begin
      errors++; $display("FAIL b2b_post got %0d exp 4", bus.o_fsm_state);
    end
    tick();
    tick();
    checks++;
    if (bus.o_fsm_state !== 3'd0) begin
      errors++; $display("FAIL b2b_idle got %0d exp 0", bus.o_fsm_state);
    end
  endtask

  task automatic test_async_reset();
    cfg(2'b00, 1'b0, 3'd2, 2'd2);
    bus.i_pre_pattern = 8'h0C;
    cmd();
    pre2();
    for (int i = 0; i < 3; i++) begin
      bus.i_DQ = 8'h11 * 8'(i + 1);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_rd_data_valid, bus.o_rd_data, bus.o_busy, bus.o_fsm_state} !== 13'h0) begin
      errors++; $display("FAIL arst_outputs got v=%b d=%h b=%b st=%0d exp zeros", bus.o_rd_data_valid,
                         bus.o_rd_data, bus.o_busy, bus.o_fsm_state);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.o_fsm_state !== 3'd0) begin
      errors++; $display("FAIL arst_release got %0d exp 0", bus.o_fsm_state);
    end
  endtask

  task automatic test_enable_low();
    cfg(2'b00, 1'b0, 3'd2, 2'd2);
    bus.i_pre_pattern = 8'h0C;
    cmd();
    pre2();
    for (int i = 0; i < 3; i++) begin
      bus.i_DQ = 8'h21 + 8'(i);
      tick();
    end
    bus.i_enable = 1'b0;
    #1;
    checks++;
    if (bus.o_rd_data_valid !== 1'b0) begin
      errors++; $display("FAIL en_valid got %b exp 0", bus.o_rd_data_valid);
    end
    bus.i_rd_en = 1'b1;
    tick();
    checks++;
    if ({bus.o_busy, bus.o_fsm_state, bus.o_rd_data} !== 12'h0) begin
      errors++; $display("FAIL en_idle got b=%b st=%0d d=%h exp zeros", bus.o_busy, bus.o_fsm_state, bus.o_rd_data);
    end
    tick();
    checks++;
    if (bus.o_fsm_state !== 3'd0) begin
      errors++; $display("FAIL en_ignore_rd got %0d exp 0", bus.o_fsm_state);
    end
    bus.i_rd_en  = 1'b0;
    bus.i_enable = 1'b1;
    tick();
  endtask

  task automatic test_clamp();
    cfg(2'b01, 1'b0, 3'd0, 2'd0);
    bus.i_pre_pattern = 8'hC6;
    cmd();
    bus.i_DQS = 2'b11; tick();
    bus.i_DQS = 2'b00; tick();
    bus.i_DQS = 2'b01; tick();
    checks++;
    if (bus.o_fsm_state !== 3'd1) begin
      errors++; $display("FAIL clamp_early got %0d exp 1", bus.o_fsm_state);
    end
    bus.i_DQS = 2'b10; tick();
    bus.i_DQS = 2'b00;
    checks++;
    if (bus.o_fsm_state !== 3'd2) begin
      errors++; $display("FAIL clamp_detect got %0d exp 2", bus.o_fsm_state);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.o_fsm_state !== 3'd0) begin
      errors++; $display("FAIL clamp_end got %0d exp 0", bus.o_fsm_state);
    end
  endtask

  initial begin
    bus.i_enable = 1'b1;   bus.i_rd_en = 1'b0;      bus.i_crc_en = 1'b0;
    bus.i_burstlength = '0; bus.i_precycle = 3'd2;  bus.i_postcycle = '0;
    bus.i_pre_pattern = 8'h0C; bus.i_DQ = '0;       bus.i_DQS = '0;
    bus.i_crc_code = '0;
    test_reset();
    test_bl16();
    test_crc(1'b0);
    test_crc(1'b1);
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_bl16();
    test_enable_low();
    test_bl16();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/read_manager.md
Name: read_manager

Overview:
- Receive-side counterpart of the DDR5 PHY write manager.
- After a read command, searches the DRAM-driven DQS for the programmed read preamble and captures the BL-sized DQ burst.
- Optionally streams data to the external CRC engine and checks the trailing CRC beat, then tracks the postamble.
- Sits between the DQ/DQS input capture and the controller-side read-data interface; single clock, DDR beats pre-packed two per cycle.

Parameters:
N, 4, DRAM device width; DQ carries 2*N bits per clock (rising beat in [N-1:0], falling beat in [2N-1:N]).
TIMEOUT, 16, max cycles from command to preamble detect before error.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_enable  in  1  block enable; low forces IDLE
i_rd_en  in  1  read command pulse
i_crc_en  in  1  read CRC enabled for this burst (sampled with i_rd_en)
i_burstlength  in  2  00 BL16 (8 cyc), 01 BC8 (4 cyc), 10 BL32 (16 cyc), 11 treated as BL16
i_precycle  in  3  preamble length in cycles, legal 1..4
i_postcycle  in  2  postamble length in cycles, 0..2
i_pre_pattern  in  8  expected DQS preamble; low 2*i_precycle bits used, bit0 is the last sampled half
i_DQ  in  2N  captured DQ
i_DQS  in  2  captured DQS halves ([0] rising, [1] falling)
i_crc_code  in  2N  CRC computed by the external engine over o_crc_data
o_rd_data  out  2N  read data
o_rd_data_valid  out  1  read data qualifier
o_crc_data  out  2N  data to the CRC engine
o_crc_enable  out  1  CRC engine accumulate strobe
o_crc_error  out  1  one-cycle pulse, CRC mismatch
o_preamble_error  out  1  one-cycle pulse, preamble timeout
o_cmd_overflow  out  1  one-cycle pulse, read command dropped
o_busy  out  1  FSM not in IDLE
o_fsm_state  out  3  current state encoding

Behaviour:
- Reset: all outputs 0, FSM IDLE, pending flag 0, DQS history 0, counters 0.
- States: IDLE=0, WAIT_PRE=1, DATA=2, CRC=3, POST=4.
- IDLE: on i_rd_en, latch burstlength, crc_en, precycle and postcycle into shadow registers, then go to WAIT_PRE. Shadow values apply for the whole burst.
- WAIT_PRE:
  - Shift i_DQS into an 8-bit history, 2 bits per cycle (new pair enters at [1:0]).
  - Match when history[2*prec-1:0] == i_pre_pattern[2*prec-1:0]; on match go to DATA next cycle.
  - The timeout counter runs from entry. On reaching TIMEOUT without a match, pulse o_preamble_error and go to IDLE.
  - The pending command, if any, is then served.
- DATA:
  - Each cycle, register i_DQ into o_rd_data with o_rd_data_valid=1; output latency is 1 cycle.
  - The same data drives o_crc_data with o_crc_enable=1, but only when crc_en is set.
  - The beat counter counts burst cycles. At the last beat go to CRC if crc_en, else POST.
- CRC:
  - One cycle. Compare i_DQ with i_crc_code and register the result.
  - o_crc_error pulses the next cycle on mismatch.
  - No o_rd_data_valid is asserted in this state.
- POST:
  - Lasts postcycle cycles; postcycle=0 means one transit cycle through POST.
  - Then go to IDLE, or to WAIT_PRE if pending is set.
- Back-to-back:
  - i_rd_en while busy sets the pending flag and stores its config.
  - If the current burst finishes with pending set, go DATA/CRC→WAIT_PRE directly (interamble: POST skipped) and clear pending.
  - i_rd_en while pending is already set pulses o_cmd_overflow; that command is dropped.
- Simultaneous events:
  - i_rd_en in the same cycle the FSM returns to IDLE is accepted as a new command, not as pending.
  - A preamble match and timeout expiry in the same cycle: the match wins.
- i_enable low:
  - FSM goes to IDLE next cycle and pending is cleared.
  - Valids and enables go low the same cycle.
  - i_rd_en is ignored.
- i_precycle of 0 or greater than 4 is clamped to 4.

Decomposition:
- Shared package read_pkg holds:
  - the state enum,
  - burst-length codes,
  - a function returning burst cycle count from code.
- Sub-module read_preamble_detect holds the DQS history register, the pattern compare and the timeout counter. It outputs a detect pulse and a timeout pulse.

Test Plan:
- BL16, no CRC, precycle=2, pattern 8'h0C, DQ 8'h01..8'h08 after preamble → 8 valid beats 01..08, each 1 cycle after input; o_busy drops after postcycle; no error pulses.
- CRC on, BC8, DQ 8'hA0..A3 then CRC beat equal to i_crc_code → o_crc_enable high for 4 cycles, o_crc_error stays 0. Repeat with CRC beat ^ 8'h01 → single o_crc_error pulse.
- DQS held 2'b00 after i_rd_en, TIMEOUT=16 → o_preamble_error pulses 16 cycles after entry; FSM returns to 0.
- Second i_rd_en during DATA → POST skipped, FSM 2→1, second burst captured. Third i_rd_en while pending → o_cmd_overflow pulse.
- Asynchronous i_rst low mid-DATA → all outputs 0 immediately. Same for i_enable low mid-DATA, except outputs go 0 within one cycle. After release, a fresh BL16 read completes normally.
